instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  word address of the outstanding fetch.
REQ-006 imem_ready  input  1  memory returns imem_rdata this cycle; completes the request.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 instr_valid  output  1  instrCode/instr_pc hold a valid instruction for decode.
REQ-009 instrCode  output  32  instruction presented to the control unit and register file.
REQ-010 instr_pc  output  32  address of instrCode.
REQ-011 instr_ready  input  1  downstream consumes instrCode this cycle when instr_valid=1.
REQ-012 redirect  input  1  taken branch, JAL or JALR resolved downstream.
REQ-013 redirect_pc  input  32  target of the redirect.

Function
REQ-014 FSM states: IDLE, FETCH, HOLD, DROP; state held in a register.
REQ-015 imem_req SHALL be 1 exactly in FETCH and DROP; imem_addr SHALL equal the internal pc register and stay stable while imem_req=1 and imem_ready=0.
REQ-016 IDLE -> FETCH unconditionally on the first clock after reset release.
REQ-017 FETCH, imem_ready=1, redirect=0: latch imem_rdata into instrCode, pc into instr_pc, set instr_valid, go HOLD (1-cycle latency from ready to valid).
REQ-018 HOLD, instr_ready=1, redirect=0: clear instr_valid, pc <= pc+4, go FETCH; max throughput one instruction per 2 cycles with zero-wait memory.
REQ-019 HOLD, instr_ready=0, redirect=0: hold instrCode, instr_pc, instr_valid unchanged.
REQ-020 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-021 Redirect target SHALL be {redirect_pc[31:2], 2'b00}; low two bits always forced to zero.
REQ-022 redirect in HOLD: drop buffered instruction (instr_valid <= 0), pc <= target, go FETCH; instr_ready ignored that cycle.
REQ-023 redirect in FETCH with imem_ready=1: discard imem_rdata, instr_valid stays 0, pc <= target, stay FETCH.
REQ-024 redirect in FETCH with imem_ready=0: store target in pending register, go DROP; imem_addr unchanged.
REQ-025 DROP: keep imem_req=1 with old address; on imem_ready=1 discard data, pc <= pending target, go FETCH.
REQ-026 redirect in DROP: overwrite pending target with newest target; if imem_ready=1 same cycle, the newest target is used.
REQ-027 redirect in IDLE: ignored.
REQ-028 instr_valid SHALL never be 1 in FETCH, DROP or IDLE.
REQ-029 instrCode SHALL be NOP (32'h0000_0013) whenever instr_valid=0.

Reset
REQ-030 On reset_n=0, immediately: state=IDLE, pc=RESET_PC, pending target=RESET_PC, instr_valid=0, instrCode=32'h0000_0013, instr_pc=RESET_PC, imem_req=0.
REQ-031 Reset asserted mid-request (FETCH/DROP) SHALL abandon the request; a late imem_ready after reset release in IDLE is ignored.

Structure
REQ-032 Shared package holds the fetch-state enum, NOP constant and RESET_PC default; opcode defines remain in the existing defines file.
REQ-033 No sub-module; pc register, pending-target register and instruction buffer stay inline.

Verification
REQ-034 Reset release, imem_ready tied 1 -> fetches at 0x0, 0x4, 0x8; instr_valid every second cycle with instr_pc matching.
REQ-035 imem_ready delayed 3 cycles -> imem_addr stable 0x0 for 4 cycles; instr_valid one cycle after ready.
REQ-036 HOLD at pc 0x10, instr_ready=0 for 5 cycles -> instrCode/instr_pc frozen; then redirect_pc=0x103 -> next imem_addr 0x100, instr_valid=0.
REQ-037 Redirect to 0x200 while FETCH of 0x8 waits -> DROP, addr stays 0x8; ready returns 0xDEADBEEF -> discarded, next fetch 0x200.
REQ-038 Redirects to 0x300 then 0x400 during DROP -> next fetch 0x400.
REQ-039 pc 0xFFFF_FFFC consumed -> next imem_addr 0x0; reset_n pulsed mid-FETCH -> outputs at reset values, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: fetch-state encoding,
// the canonical NOP word and the default boot address.
package instr_fetch_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE  = 2'd0;
  localparam fetch_state_t ST_FETCH = 2'd1;
  localparam fetch_state_t ST_HOLD  = 2'd2;
  localparam fetch_state_t ST_DROP  = 2'd3;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] align_target(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one word fetch at a time, buffers the result
// for decode and handles redirects, including ones that arrive mid-request.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instrCode,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_q, pend_d;
  logic         valid_q, valid_d;
  logic [31:0]  code_q, code_d;
  logic [31:0]  ipc_q, ipc_d;
  logic [31:0]  target;

  assign target      = align_target(redirect_pc);
  assign imem_req    = (state_q == ST_FETCH) || (state_q == ST_DROP);
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instrCode   = code_q;
  assign instr_pc    = ipc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    code_d  = code_q;
    ipc_d   = ipc_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ready) begin
          if (redirect) begin
            pc_d = target;
          end else begin
            code_d  = imem_rdata;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            state_d = ST_HOLD;
          end
        end else if (redirect) begin
          // The request cannot be withdrawn, so park the target until it completes
          pend_d  = target;
          state_d = ST_DROP;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          valid_d = 1'b0;
          code_d  = NOP_INSTR;
          pc_d    = target;
          state_d = ST_FETCH;
        end else if (instr_ready) begin
          valid_d = 1'b0;
          code_d  = NOP_INSTR;
          pc_d    = pc_q + 32'd4;
          state_d = ST_FETCH;
        end
      end
      ST_DROP: begin
        if (redirect) begin
          pend_d = target;
        end
        if (imem_ready) begin
          pc_d    = redirect ? target : pend_q;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= RESET_PC;
      valid_q <= 1'b0;
      code_q  <= NOP_INSTR;
      ipc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      ipc_q   <= ipc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a small memory model answers fetches and a
// scoreboard queue holds the instruction each accepted fetch should deliver.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instrCode;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        use_ovr;
  logic [31:0] ovr_data;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] code;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] hold_code;
  logic [31:0] hold_pc;

  instr_fetch #(.RESET_PC(RPC)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instrCode   (instrCode),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'h5A5A_0003;
  endfunction

  assign imem_rdata = use_ovr ? ovr_data : mem_fn(imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expect FETCH at exp_pc, complete it with zero wait, then check the buffered word
  task automatic applyStimulus(input logic [31:0] exp_pc);
    exp_t e;
    checkOutput("fetch_req", {31'd0, imem_req}, 32'd1);
    checkOutput("fetch_addr", imem_addr, exp_pc);
    checkOutput("fetch_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("fetch_nop", instrCode, NOP);
    e.pc   = exp_pc;
    e.code = mem_fn(exp_pc);
    sb.push_back(e);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    checkOutput("hold_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("hold_req", {31'd0, imem_req}, 32'd0);
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      checkOutput("instr_code", instrCode, e.code);
      checkOutput("instr_pc", instr_pc, e.pc);
      hold_code = e.code;
      hold_pc   = e.pc;
    end
  endtask

  task automatic consume();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    checkOutput("consume_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("consume_nop", instrCode, NOP);
  endtask

  initial begin
    reset_n     = 1'b0;
    imem_ready  = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    use_ovr     = 1'b0;
    ovr_data    = 32'd0;
    hold_code   = 32'd0;
    hold_pc     = 32'd0;

    #12;
    checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
    checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rst_code", instrCode, NOP);
    checkOutput("rst_ipc", instr_pc, RPC);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Memory stalls three cycles: address must hold at the reset PC
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_addr", imem_addr, RPC);
      checkOutput("stall_req", {31'd0, imem_req}, 32'd1);
      checkOutput("stall_valid", {31'd0, instr_valid}, 32'd0);
      tick();
    end
    applyStimulus(32'h0);
    consume();
    applyStimulus(32'h4);
    consume();
    applyStimulus(32'h8);
    consume();
    applyStimulus(32'hC);
    consume();

    // Decode stalls at 0x10, then a misaligned redirect drops the buffer
    applyStimulus(32'h10);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("frozen_valid", {31'd0, instr_valid}, 32'd1);
      checkOutput("frozen_code", instrCode, hold_code);
      checkOutput("frozen_pc", instr_pc, hold_pc);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    instr_ready = 1'b1;
    tick();
    redirect    = 1'b0;
    instr_ready = 1'b0;
    checkOutput("hold_redir_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("hold_redir_code", instrCode, NOP);
    checkOutput("hold_redir_addr", imem_addr, 32'h100);
    applyStimulus(32'h100);
    consume();

    // Redirect coinciding with a completing fetch discards its data
    redirect    = 1'b1;
    redirect_pc = 32'h8;
    imem_ready  = 1'b1;
    tick();
    redirect    = 1'b0;
    imem_ready  = 1'b0;
    checkOutput("fr_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("fr_addr", imem_addr, 32'h8);
    checkOutput("fr_req", {31'd0, imem_req}, 32'd1);

    // Redirect while fetch of 0x8 waits: DROP keeps the old address
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    checkOutput("drop_addr0", imem_addr, 32'h8);
    checkOutput("drop_req0", {31'd0, imem_req}, 32'd1);
    tick();
    checkOutput("drop_addr1", imem_addr, 32'h8);
    use_ovr    = 1'b1;
    ovr_data   = 32'hDEAD_BEEF;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    use_ovr    = 1'b0;
    checkOutput("drop_done_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("drop_done_code", instrCode, NOP);
    applyStimulus(32'h200);
    consume();

    // Two redirects during DROP: newest wins
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect_pc = 32'h400;
    tick();
    redirect = 1'b0;
    tick();
    checkOutput("drop2_addr", imem_addr, 32'h204);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    checkOutput("drop2_next", imem_addr, 32'h400);
    checkOutput("drop2_valid", {31'd0, instr_valid}, 32'd0);

    // Redirect in DROP on the completing cycle uses the newest target
    redirect    = 1'b1;
    redirect_pc = 32'h600;
    tick();
    redirect_pc = 32'h702;
    imem_ready  = 1'b1;
    tick();
    redirect   = 1'b0;
    imem_ready = 1'b0;
    checkOutput("drop3_next", imem_addr, 32'h700);

    // PC wraps past the top of the address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    imem_ready  = 1'b1;
    tick();
    redirect   = 1'b0;
    imem_ready = 1'b0;
    applyStimulus(32'hFFFF_FFFC);
    consume();
    checkOutput("wrap_addr", imem_addr, 32'h0);

    // Asynchronous reset mid-FETCH, late ready and redirect during IDLE ignored
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    imem_ready  = 1'b1;
    tick();
    redirect   = 1'b0;
    imem_ready = 1'b0;
    checkOutput("pre_rst_addr", imem_addr, 32'h40);
    reset_n = 1'b0;
    #1;
    checkOutput("arst_req", {31'd0, imem_req}, 32'd0);
    checkOutput("arst_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("arst_code", instrCode, NOP);
    checkOutput("arst_ipc", instr_pc, RPC);
    checkOutput("arst_addr", imem_addr, RPC);
    @(negedge clk);
    reset_n     = 1'b1;
    imem_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    tick();
    redirect   = 1'b0;
    imem_ready = 1'b0;
    checkOutput("idle_ign_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("idle_ign_addr", imem_addr, RPC);
    applyStimulus(RPC);
    consume();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
